// File: rtl/axi_lite_timer_slave.sv
// axi_lite_timer_slave
//   AXI4-Lite responder holding the machine timer (mtime, mtimecmp) and the
//   software interrupt bit (msip). Single-beat 64-bit accesses only.
//   Read and write channels run independent state machines over one register file.
//
// Ports
//   clk, rstn                    clock, synchronous active-low reset
//   aw*/w*/b*                    AXI-Lite write address / data / response channels
//   ar*/r*                       AXI-Lite read address / data channels
//   mtip                         timer interrupt pending (mtime >= mtimecmp, unsigned)
//   msip                         software interrupt pending
//
// Register map (offset from BASE_ADDR, addr[2:0] ignored)
//   0x00 mtime, 0x08 mtimecmp, 0x10 msip (bit 0), 0x18 reserved (reads 0)
//   Any other address answers DECERR with rdata 0 and no write.
module axi_lite_timer_slave #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    mtip,
  output logic                    msip
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_WAIT_W = 2'd1;
  localparam logic [1:0] W_WAIT_A = 2'd2;
  localparam logic [1:0] W_RESP   = 2'd3;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_DATA   = 1'b1;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] DECERR   = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
  } wreq_t;

  logic [63:0] mtime, mtimecmp;
  logic        msip_r;
  logic [31:0] presc;
  logic        tick;

  logic [1:0]  wstate;
  logic [0:0]  rstate;
  wreq_t       wlat;   // whichever half of the write arrived first
  wreq_t       wreq;   // the complete write being committed this cycle
  logic        wr_go;
  logic        wr_hit, rd_hit;
  logic [1:0]  wr_idx, rd_idx;
  logic [63:0] rd_val;

  // {hit, register index}; hit is false below the base or past the 32-byte window
  function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] off;
    off = 64'(a) - BASE_ADDR;
    return {(64'(a) >= BASE_ADDR) && (off < 64'h20), off[4:3]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // A write commits on the cycle the second of AW/W is accepted; the half that
  // arrives in this cycle comes from the bus, the other from the latch.
  always_comb begin
    wr_go = 1'b0;
    wreq  = '0;
    case (wstate)
      W_IDLE:   if (awvalid && wvalid) begin
                  wr_go = 1'b1;
                  wreq  = '{addr: awaddr, data: wdata, strb: wstrb};
                end
      W_WAIT_W: if (wvalid) begin
                  wr_go = 1'b1;
                  wreq  = '{addr: wlat.addr, data: wdata, strb: wstrb};
                end
      W_WAIT_A: if (awvalid) begin
                  wr_go = 1'b1;
                  wreq  = '{addr: awaddr, data: wlat.data, strb: wlat.strb};
                end
      default: ;
    endcase
  end

  assign {wr_hit, wr_idx} = decode(wreq.addr);
  assign {rd_hit, rd_idx} = decode(araddr);

  always_comb begin
    rd_val = 64'h0;
    case (rd_idx)
      2'd0:    rd_val = mtime;
      2'd1:    rd_val = mtimecmp;
      2'd2:    rd_val = {63'h0, msip_r};
      default: rd_val = 64'h0;
    endcase
  end

  assign tick = (presc == 32'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wstate   <= W_IDLE;
      rstate   <= R_IDLE;
      wlat     <= '0;
      bresp    <= OKAY;
      rresp    <= OKAY;
      rdata    <= '0;
      mtime    <= 64'h0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r   <= 1'b0;
      presc    <= 32'h0;
    end else begin
      case (wstate)
        W_IDLE:
          if (awvalid && wvalid) wstate <= W_RESP;
          else if (awvalid) begin
            wstate    <= W_WAIT_W;
            wlat.addr <= awaddr;
          end else if (wvalid) begin
            wstate    <= W_WAIT_A;
            wlat.data <= wdata;
            wlat.strb <= wstrb;
          end
        W_WAIT_W: if (wvalid)  wstate <= W_RESP;
        W_WAIT_A: if (awvalid) wstate <= W_RESP;
        default:  if (bready)  wstate <= W_IDLE;
      endcase
      if (wr_go) bresp <= wr_hit ? OKAY : DECERR;

      // A real write to mtime overrides the tick and restarts the prescaler.
      if (wr_go && wr_hit && wr_idx == 2'd0 && |wreq.strb) begin
        mtime <= merge(mtime, wreq.data, wreq.strb);
        presc <= 32'h0;
      end else if (tick) begin
        mtime <= mtime + 64'h1;
        presc <= 32'h0;
      end else begin
        presc <= presc + 32'h1;
      end
      if (wr_go && wr_hit && wr_idx == 2'd1)
        mtimecmp <= merge(mtimecmp, wreq.data, wreq.strb);
      if (wr_go && wr_hit && wr_idx == 2'd2 && wreq.strb[0])
        msip_r <= wreq.data[0];

      // Read data is captured from the registers as they stand in the AR
      // handshake cycle, so a same-cycle write commit is not visible.
      case (rstate)
        R_IDLE:
          if (arvalid) begin
            rstate <= R_DATA;
            rdata  <= rd_hit ? rd_val : 64'h0;
            rresp  <= rd_hit ? OKAY : DECERR;
          end
        default: if (rready) rstate <= R_IDLE;
      endcase
    end
  end

  assign awready = (wstate == W_IDLE) || (wstate == W_WAIT_A);
  assign wready  = (wstate == W_IDLE) || (wstate == W_WAIT_W);
  assign bvalid  = (wstate == W_RESP);
  assign arready = (rstate == R_IDLE);
  assign rvalid  = (rstate == R_DATA);
  assign mtip    = (mtime >= mtimecmp);
  assign msip    = msip_r;

endmodule
